// File: rtl/cmp_event_monitor.sv
// cmp_event_monitor
//   Watches the less/greater/equal flags of an upstream comparator. It locks
//   onto a relation that repeats for STABLE_CNT accepted samples. It reports a
//   crossing each time the last non-EQ relation flips between LT and GT. It
//   keeps saturating per-relation statistics. It flags, and holds, any valid
//   sample whose flags are not one-hot.
//
// Ports
//   clk        in   clock; all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   less/greater/equal carry a sample this cycle
//   less       in   comparator flag a<b
//   greater    in   comparator flag a>b
//   equal      in   comparator flag a==b
//   clear      in   synchronous clear of all state; wins over in_valid
//   stable     out  FSM is LOCKED
//   stable_rel out  locked relation (00 none, 01 LT, 10 GT, 11 EQ)
//   cross_up   out  one-cycle pulse: last non-EQ relation went LT -> GT
//   cross_dn   out  one-cycle pulse: last non-EQ relation went GT -> LT
//   err_onehot out  sticky: a valid sample was not one-hot
//   lt_count   out  saturating count of accepted LT samples
//   gt_count   out  saturating count of accepted GT samples
//   eq_count   out  saturating count of accepted EQ samples
//   dbg_state  out  FSM state (00 IDLE, 01 TRACK, 10 LOCKED)
//
// Handshake: a sample is taken only in a cycle where in_valid=1 and clear=0.
// There is no backpressure. All outputs are registered, so they show the
// effect of a sample one cycle after it is taken.

module cmp_event_monitor #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             less,
  input  logic             greater,
  input  logic             equal,
  input  logic             clear,
  output logic             stable,
  output logic [1:0]       stable_rel,
  output logic             cross_up,
  output logic             cross_dn,
  output logic             err_onehot,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_TRACK  = 2'b01,
    S_LOCKED = 2'b10
  } state_e;

  localparam logic [1:0] REL_NONE = 2'b00;
  localparam logic [1:0] REL_LT   = 2'b01;
  localparam logic [1:0] REL_GT   = 2'b10;
  localparam logic [1:0] REL_EQ   = 2'b11;

  localparam logic [3:0]       RUN_LOCK = 4'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [1:0]       cur_rel_q, cur_rel_d;
  logic [1:0]       last_ne_q, last_ne_d;
  logic             stable_q, stable_d;
  logic [1:0]       stable_rel_q, stable_rel_d;
  logic             cross_up_q, cross_up_d;
  logic             cross_dn_q, cross_dn_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] lt_q, lt_d;
  logic [CNT_W-1:0] gt_q, gt_d;
  logic [CNT_W-1:0] eq_q, eq_d;

  logic       onehot;
  logic       accept;
  logic [1:0] samp_rel;

  assign onehot = ({less, greater, equal} == 3'b100) ||
                  ({less, greater, equal} == 3'b010) ||
                  ({less, greater, equal} == 3'b001);
  assign accept = in_valid && !clear && onehot;

  always_comb begin
    samp_rel = REL_EQ;
    if (less)         samp_rel = REL_LT;
    else if (greater) samp_rel = REL_GT;
  end

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    cur_rel_d    = cur_rel_q;
    last_ne_d    = last_ne_q;
    err_d        = err_q;
    lt_d         = lt_q;
    gt_d         = gt_q;
    eq_d         = eq_q;
    cross_up_d   = 1'b0;
    cross_dn_d   = 1'b0;
    stable_d     = 1'b0;
    stable_rel_d = REL_NONE;

    if (clear) begin
      state_d   = S_IDLE;
      run_d     = 4'd0;
      cur_rel_d = REL_NONE;
      last_ne_d = REL_NONE;
      err_d     = 1'b0;
      lt_d      = '0;
      gt_d      = '0;
      eq_d      = '0;
    end else if (in_valid && !onehot) begin
      err_d = 1'b1;
    end else if (accept) begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_TRACK;
          run_d     = 4'd1;
          cur_rel_d = samp_rel;
        end
        default: begin
          if (samp_rel == cur_rel_q) begin
            if (run_q < RUN_LOCK) run_d = run_q + 4'd1;
            state_d = (run_d >= RUN_LOCK) ? S_LOCKED : S_TRACK;
          end else begin
            state_d   = S_TRACK;
            run_d     = 4'd1;
            cur_rel_d = samp_rel;
          end
        end
      endcase

      // Crossings are judged against the last non-EQ relation, so EQ
      // samples in between neither pulse nor break the pending crossing.
      cross_up_d = (samp_rel == REL_GT) && (last_ne_q == REL_LT);
      cross_dn_d = (samp_rel == REL_LT) && (last_ne_q == REL_GT);
      if (samp_rel != REL_EQ) last_ne_d = samp_rel;

      case (samp_rel)
        REL_LT:  if (lt_q != CNT_MAX) lt_d = lt_q + 1'b1;
        REL_GT:  if (gt_q != CNT_MAX) gt_d = gt_q + 1'b1;
        default: if (eq_q != CNT_MAX) eq_d = eq_q + 1'b1;
      endcase
    end

    // Registered lock indication follows the next state directly.
    if (state_d == S_LOCKED) begin
      stable_d     = 1'b1;
      stable_rel_d = cur_rel_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      run_q        <= 4'd0;
      cur_rel_q    <= REL_NONE;
      last_ne_q    <= REL_NONE;
      stable_q     <= 1'b0;
      stable_rel_q <= REL_NONE;
      cross_up_q   <= 1'b0;
      cross_dn_q   <= 1'b0;
      err_q        <= 1'b0;
      lt_q         <= '0;
      gt_q         <= '0;
      eq_q         <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      cur_rel_q    <= cur_rel_d;
      last_ne_q    <= last_ne_d;
      stable_q     <= stable_d;
      stable_rel_q <= stable_rel_d;
      cross_up_q   <= cross_up_d;
      cross_dn_q   <= cross_dn_d;
      err_q        <= err_d;
      lt_q         <= lt_d;
      gt_q         <= gt_d;
      eq_q         <= eq_d;
    end
  end

  assign stable     = stable_q;
  assign stable_rel = stable_rel_q;
  assign cross_up   = cross_up_q;
  assign cross_dn   = cross_dn_q;
  assign err_onehot = err_q;
  assign lt_count   = lt_q;
  assign gt_count   = gt_q;
  assign eq_count   = eq_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cmp_event_monitor.sv
// Directed bench for cmp_event_monitor. The driver issues one sample per
// step and pushes the hand-computed outputs expected after that clock edge.
// The monitor pops and compares each entry just after the edge.
// Expected vector layout (32 bits):
//   {stable, stable_rel[1:0], cross_up, cross_dn, err_onehot,
//    lt_count[7:0], gt_count[7:0], eq_count[7:0], lt_count of the CNT_W=2 copy}

module tb_cmp_event_monitor;

  logic clk;
  logic rst_n;
  logic in_valid, less, greater, equal, clear;

  logic       stable, cross_up, cross_dn, err_onehot;
  logic [1:0] stable_rel, dbg_state;
  logic [7:0] lt_count, gt_count, eq_count;

  logic       s2_stable, s2_cross_up, s2_cross_dn, s2_err;
  logic [1:0] s2_rel, s2_state;
  logic [1:0] s2_lt, s2_gt, s2_eq;

  logic [31:0] exp_q[$];
  int          step_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          step_no  = 0;

  cmp_event_monitor #(.STABLE_CNT(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .less(less),
    .greater(greater), .equal(equal), .clear(clear),
    .stable(stable), .stable_rel(stable_rel), .cross_up(cross_up),
    .cross_dn(cross_dn), .err_onehot(err_onehot), .lt_count(lt_count),
    .gt_count(gt_count), .eq_count(eq_count), .dbg_state(dbg_state)
  );

  cmp_event_monitor #(.STABLE_CNT(4), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .less(less),
    .greater(greater), .equal(equal), .clear(clear),
    .stable(s2_stable), .stable_rel(s2_rel), .cross_up(s2_cross_up),
    .cross_dn(s2_cross_dn), .err_onehot(s2_err), .lt_count(s2_lt),
    .gt_count(s2_gt), .eq_count(s2_eq), .dbg_state(s2_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running exp finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] actual_vec();
    return {stable, stable_rel, cross_up, cross_dn, err_onehot,
            lt_count, gt_count, eq_count, s2_lt};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [31:0] e;
      int          s;
      e = exp_q.pop_front();
      s = step_q.pop_front();
      n_checks++;
      if (actual_vec() !== e) begin
        n_errors++;
        $display("FAIL step%0d got=%h exp=%h", s, actual_vec(), e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_now(input string name, input logic [31:0] e);
    n_checks++;
    if (actual_vec() !== e) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, actual_vec(), e);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic v, input logic l, input logic g,
                      input logic e, input logic clr,
                      input logic x_st, input logic [1:0] x_rel,
                      input logic x_cu, input logic x_cd, input logic x_err,
                      input int x_lt, input int x_gt, input int x_eq,
                      input int x_lt2);
    step_no++;
    in_valid = v; less = l; greater = g; equal = e; clear = clr;
    exp_q.push_back({x_st, x_rel, x_cu, x_cd, x_err,
                     8'(x_lt), 8'(x_gt), 8'(x_eq), 2'(x_lt2)});
    step_q.push_back(step_no);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; less = 1'b0; greater = 1'b0; equal = 1'b0; clear = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; less = 1'b0; greater = 1'b0; equal = 1'b0; clear = 1'b0;
    #3;
    check_now("reset_state", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // four LT (a=14,b=15): lock only after the 4th
    step(1,1,0,0,0, 0,2'b00,0,0,0, 1,0,0,1);
    step(1,1,0,0,0, 0,2'b00,0,0,0, 2,0,0,2);
    step(1,1,0,0,0, 0,2'b00,0,0,0, 3,0,0,3);
    step(1,1,0,0,0, 1,2'b01,0,0,0, 4,0,0,3);
    // GT (a=14,b=5): cross_up, lock dropped; then EQ (a=14,b=14)
    step(1,0,1,0,0, 0,2'b00,1,0,0, 4,1,0,3);
    step(1,0,0,1,0, 0,2'b00,0,0,0, 4,1,1,3);
    // non-one-hot valid sample, then ignored invalid samples, valid 000
    step(1,1,1,0,0, 0,2'b00,0,0,1, 4,1,1,3);
    step(0,0,0,0,0, 0,2'b00,0,0,1, 4,1,1,3);
    step(0,1,1,1,0, 0,2'b00,0,0,1, 4,1,1,3);
    step(1,0,0,0,0, 0,2'b00,0,0,1, 4,1,1,3);
    // LT after GT,EQ: cross_dn; LT,EQ,EQ,GT is one crossing up
    step(1,1,0,0,0, 0,2'b00,0,1,1, 5,1,1,3);
    step(1,0,0,1,0, 0,2'b00,0,0,1, 5,1,2,3);
    step(1,0,0,1,0, 0,2'b00,0,0,1, 5,1,3,3);
    step(1,0,1,0,0, 0,2'b00,1,0,1, 5,2,3,3);
    // back-to-back crossings
    step(1,1,0,0,0, 0,2'b00,0,1,1, 6,2,3,3);
    step(1,0,1,0,0, 0,2'b00,1,0,1, 6,3,3,3);
    // GT run to lock
    step(1,0,1,0,0, 0,2'b00,0,0,1, 6,4,3,3);
    step(1,0,1,0,0, 0,2'b00,0,0,1, 6,5,3,3);
    step(1,0,1,0,0, 1,2'b10,0,0,1, 6,6,3,3);
    // clear with a simultaneous LT while LOCKED
    step(1,1,0,0,1, 0,2'b00,0,0,0, 0,0,0,0);
    // five LT: narrow counter 1,2,3,3,3; no pulse on first after clear
    step(1,1,0,0,0, 0,2'b00,0,0,0, 1,0,0,1);
    step(1,1,0,0,0, 0,2'b00,0,0,0, 2,0,0,2);
    step(1,1,0,0,0, 0,2'b00,0,0,0, 3,0,0,3);
    step(1,1,0,0,0, 1,2'b01,0,0,0, 4,0,0,3);
    step(1,1,0,0,0, 1,2'b01,0,0,0, 5,0,0,3);
    // into TRACK on GT, then async reset between edges
    step(1,0,1,0,0, 0,2'b00,1,0,0, 5,1,0,3);
    step(1,0,1,0,0, 0,2'b00,0,0,0, 5,2,0,3);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset_midrun", 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // three GT then LT: first GT no crossing, LT gives cross_dn
    step(1,0,1,0,0, 0,2'b00,0,0,0, 0,1,0,0);
    step(1,0,1,0,0, 0,2'b00,0,0,0, 0,2,0,0);
    step(1,0,1,0,0, 0,2'b00,0,0,0, 0,3,0,0);
    step(1,1,0,0,0, 0,2'b00,0,1,0, 1,3,0,1);

    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cmp_event_monitor.md
CMP_EVENT_MONITOR -- requirements
Module: cmp_event_monitor

Interface
REQ-001 Parameter STABLE_CNT, default 4, meaning consecutive identical relations needed to lock (legal range 2..15).
REQ-002 Parameter CNT_W, default 8, meaning width of the saturating statistics counters.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  the less/greater/equal flags are a sample this cycle.
REQ-006 less  in  1  upstream 4-bit comparator flag, a<b.
REQ-007 greater  in  1  upstream comparator flag, a>b.
REQ-008 equal  in  1  upstream comparator flag, a==b.
REQ-009 clear  in  1  synchronous clear of all state and statistics.
REQ-010 stable  out  1  high while the FSM is in LOCKED.
REQ-011 stable_rel  out  2  locked relation: 00 none, 01 LT, 10 GT, 11 EQ.
REQ-012 cross_up  out  1  one-cycle pulse, last non-EQ relation went LT to GT.
REQ-013 cross_dn  out  1  one-cycle pulse, last non-EQ relation went GT to LT.
REQ-014 err_onehot  out  1  sticky: a valid sample had flags that were not exactly one-hot.
REQ-015 lt_count, gt_count, eq_count  out  CNT_W each  saturating count of accepted LT/GT/EQ samples.

Function
REQ-016 A sample is accepted when in_valid=1, clear=0 and {less,greater,equal} is exactly one-hot; all outputs are registered and reflect it on the following cycle (latency 1).
REQ-017 A valid non-one-hot sample (000, 011, 101, 110, 111) shall set err_onehot and shall leave FSM state, run counter, last relation and all counters unchanged.
REQ-018 Flags with in_valid=0 shall be ignored entirely, including for err_onehot.
REQ-019 FSM states: IDLE (no accepted sample since reset/clear), TRACK (run < STABLE_CNT), LOCKED (run >= STABLE_CNT).
REQ-020 IDLE -> TRACK on the first accepted sample; run=1, cur_rel=sample relation.
REQ-021 TRACK/LOCKED, accepted sample equal to cur_rel: run increments, saturating at STABLE_CNT; TRACK -> LOCKED when run reaches STABLE_CNT.
REQ-022 TRACK/LOCKED, accepted sample differing from cur_rel: run=1, cur_rel=new relation, state -> TRACK (LOCKED is dropped the next cycle).
REQ-023 stable_rel shall equal cur_rel encoding while LOCKED and 00 otherwise.
REQ-024 A last_ne register shall hold the last accepted non-EQ relation (initially none); EQ samples shall not update it.
REQ-025 Accepted GT with last_ne=LT pulses cross_up; accepted LT with last_ne=GT pulses cross_dn; LT,EQ,EQ,GT shall count as one crossing up; first non-EQ after reset/clear shall not pulse.
REQ-026 cross_up and cross_dn shall never be high together and shall be high for exactly one cycle per crossing, including back-to-back crossings on consecutive cycles.
REQ-027 Each accepted sample increments the matching counter by 1; at 2^CNT_W-1 it shall hold (no wrap).
REQ-028 clear=1 shall have priority over a simultaneous in_valid: the sample is discarded and every register returns to its reset value on the next cycle.

Reset
REQ-029 While rst_n=0, immediately and independent of clk: state IDLE, run=0, cur_rel=none, last_ne=none, stable=0, stable_rel=00, cross_up=0, cross_dn=0, err_onehot=0, all counters 0.
REQ-030 Reset asserted mid-run shall abandon the run; the first accepted sample after rst_n rises is treated as from IDLE.
REQ-031 err_onehot shall be cleared only by rst_n or clear.

Verification
REQ-032 Four valid LT samples (a=14,b=15 -> less=1) with STABLE_CNT=4 -> stable=1, stable_rel=01 one cycle after the 4th, lt_count=4, not after the 3rd.
REQ-033 LT x4 then one GT (a=14,b=5) -> cross_up pulses one cycle, stable falls to 0, gt_count=1; then EQ (a=14,b=14) -> no pulse, eq_count=1.
REQ-034 Valid sample with less=1,greater=1 -> err_onehot=1 sticky, counters and stable unchanged; in_valid=0 with flags 000 -> no error.
REQ-035 CNT_W=2, five LT samples -> lt_count goes 1,2,3,3,3.
REQ-036 clear=1 and in_valid=1 (LT) same cycle while LOCKED -> next cycle all outputs at reset values, lt_count=0.
REQ-037 rst_n driven low between clock edges during TRACK -> outputs zero before the next edge; after release, three GT then one LT -> no cross_dn on first GT, cross_dn on the LT.
